// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ring-buffer memory bus arbiter.
package mil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Watchdog timer width; TIMEOUT must fit in it.
    localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled.
// slave: the arbiter's view. master: the view of whatever drives requests and memory responses.
interface mem_bus_arbiter_if #(
    parameter int NREQ   = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        err;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_ack;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, mem_ack,
        output ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, mem_ack,
        input  ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above i_ptr, wrapping to 0.
module rr_pick #(
    parameter int NREQ = 8
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_found,
    output logic [$clog2(NREQ)-1:0] o_index
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest candidate to i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NREQ)) begin
                w_sum = w_sum - SUM_W'(NREQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_index = w_cand;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NREQ ring-buffer requesters,
// with a per-transaction timeout watchdog.
//
// state  | meaning
// IDLE   | waiting for any req; picks next requester from ptr
// ACCESS | bus cycle in flight, mem_* held, waiting for mem_ack or timeout
// DONE   | ack/err pulse cycle; ptr advances past grant
module mem_bus_arbiter
    import mil_arb_pkg::*;
#(
    parameter int NREQ    = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);

    arb_state_t        r_state,     w_state_nx;
    logic [IDX_W-1:0]  r_ptr,       w_ptr_nx;
    logic [IDX_W-1:0]  r_grant,     w_grant_nx;
    logic [TIMER_W-1:0] r_timer,    w_timer_nx;
    logic [NREQ-1:0]   r_ack,       w_ack_nx;
    logic [NREQ-1:0]   r_err,       w_err_nx;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nx;
    logic              r_mem_req,   w_mem_req_nx;
    logic              r_mem_we,    w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nx;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nx;

    logic              w_found;
    logic [IDX_W-1:0]  w_index;
    logic [ADDR_W-1:0] w_addr_arr  [NREQ];
    logic [DATA_W-1:0] w_wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_index)
    );

    // Next-state and output decisions; mem_ack outside ACCESS is ignored.
    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_grant_nx     = r_grant;
        w_timer_nx     = r_timer;
        w_ack_nx       = '0;
        w_err_nx       = '0;
        w_rdata_nx     = r_rdata;
        w_mem_req_nx   = r_mem_req;
        w_mem_we_nx    = r_mem_we;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nx     = w_index;
                    w_mem_we_nx    = bus.we[w_index];
                    w_mem_addr_nx  = w_addr_arr[w_index];
                    w_mem_wdata_nx = w_wdata_arr[w_index];
                    w_mem_req_nx   = 1'b1;
                    w_timer_nx     = '0;
                    w_state_nx     = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    w_mem_req_nx      = 1'b0;
                    w_rdata_nx        = r_mem_we ? '0 : bus.mem_rdata;
                    w_ack_nx[r_grant] = 1'b1;
                    w_state_nx        = DONE;
                end else if (r_timer == TIMER_W'(TIMEOUT)) begin
                    w_mem_req_nx      = 1'b0;
                    w_err_nx[r_grant] = 1'b1;
                    w_state_nx        = DONE;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            DONE: begin
                w_ptr_nx   = (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset also abandons any bus cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_timer     <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_grant     <= w_grant_nx;
            r_timer     <= w_timer_nx;
            r_ack       <= w_ack_nx;
            r_err       <= w_err_nx;
            r_rdata     <= w_rdata_nx;
            r_mem_req   <= w_mem_req_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares the single external memory bus between the push/pop requesters of the ring-buffer memory block (SPI→MIL, MIL→SPI, both channels). It latches one requester's address/data, runs one memory transaction with a timeout watchdog, and returns the acknowledge and read data to that requester only. It sits between the per-channel ring-buffer ports and the memory bus pins.

## Interface
- NREQ, 8, number of requesters (min 2, max 16)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- TIMEOUT, 255, max cycles to wait for mem_ack before aborting (1..255)

- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester access request, held until ack or err
- we  in  NREQ  per-requester write (1) / read (0), valid while req
- addr  in  NREQ*ADDR_W  requester addresses, slice i = [i*ADDR_W +: ADDR_W]
- wdata  in  NREQ*DATA_W  requester write data, same slicing
- ack  out  NREQ  one-cycle completion pulse to granted requester
- err  out  NREQ  one-cycle timeout pulse to granted requester
- rdata  out  DATA_W  read data, valid in the cycle ack is high
- mem_req  out  1  bus transaction request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion, one cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req, select first set bit searching from ptr upward with wrap (ptr, ptr+1, …, NREQ-1, 0, …). At that edge: grant ← index, latch we/addr/wdata of grant into mem_we/mem_addr/mem_wdata, mem_req ← 1, timer ← 0, go ACCESS. No req: stay.
- ACCESS: mem_req held 1, mem_* stable. If mem_ack: mem_req ← 0, rdata ← mem_rdata (writes: rdata ← 0), ack[grant] ← 1, go DONE. Else if timer == TIMEOUT: mem_req ← 0, err[grant] ← 1, go DONE. Else timer+1.
- DONE: ack/err clear next edge; ptr ← grant+1 (wrap NREQ-1 → 0); go IDLE. The granted requester's req is ignored in DONE, giving it one cycle to drop req.
- mem_ack in IDLE or DONE ignored (spurious); no state change.
- Requester dropping req during ACCESS: transaction still completes; ack still pulses.
- Changing addr/wdata/we of the granted requester during ACCESS has no effect (latched).
- Timer width 8 bits; never wraps (compare stops it).

## Timing
- Reset values: state IDLE, ptr 0, grant 0, ack 0, err 0, rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, timer 0.
- rst mid-ACCESS: at that edge all outputs return to reset values; no ack/err issued; in-flight bus cycle abandoned.
- req sampled at edge N (IDLE) → mem_req high from N+1.
- mem_ack sampled at edge M → ack/rdata high for cycle M+1 only, mem_req low from M+1.
- Minimum transaction: mem_ack in first ACCESS cycle → ack one cycle after, next grant earliest 3 cycles after first grant edge.
- Timeout: no mem_ack → err high after TIMEOUT+1 ACCESS cycles.
- At most one of ack/err bits high in any cycle; never both.

## Structure
- Package mil_arb_pkg: enum arb_state_t {IDLE, ACCESS, DONE}, TIMER_W = 8.
- Sub-module rr_pick (combinational: req vector, ptr → found, index), reusable by other arbiters.
- Everything else single always_ff + always_comb in mem_bus_arbiter.

## Test plan
- Single read: req[3]=1, we[3]=0, addr3=0x0040; mem_ack 2 cycles after mem_req with mem_rdata=0xBEEF -> mem_addr=0x0040, mem_we=0, ack[3] one cycle, rdata=0xBEEF.
- Round-robin: req[0], req[5], req[7] held continuously, mem_ack immediate -> grant order 0,5,7,0; ptr wraps 7→0.
- Write latch: req[1] write addr=0x0010 wdata=0x1234, change wdata to 0xFFFF during ACCESS -> mem_wdata stays 0x1234, ack[1] pulses, rdata=0.
- Timeout: TIMEOUT=4, never assert mem_ack -> err[2] after 5 ACCESS cycles, mem_req low, ack never set, next requester granted afterwards.
- Reset mid-access: rst during ACCESS -> next cycle mem_req=0, ack=err=0, ptr=0; later req[4] granted normally.
- Spurious mem_ack in IDLE with no req -> no ack/err, state stays IDLE.
